// File: rtl/tinker_mem_arb_pkg.sv
// tinker_mem_arb_pkg: shared state/requester types and access sizes for the tinker memory arbiter
package tinker_mem_arb_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR} state_t;

    typedef enum logic {REQ_IF, REQ_D} req_t;

    localparam int IF_BYTES = 4;
    localparam int D_BYTES  = 8;

endpackage

// File: rtl/tinker_mem_arb_pick.sv
// tinker_mem_arb_pick: data-priority grant select with an anti-starvation counter that forces an IF win
module tinker_mem_arb_pick
    import tinker_mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_valid,
    input  logic d_valid,
    input  logic accept,
    output req_t grant,
    output logic forced
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve;
    logic          at_max;

    assign at_max = starve == SW'(STARVE_MAX);
    assign forced = at_max && if_valid && d_valid;
    assign grant  = (d_valid && !forced) ? REQ_D : REQ_IF;

    // Count accepts IF loses while waiting; saturate, clear once IF is accepted
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            starve <= '0;
        else if (accept)
            starve <= grant == REQ_IF ? '0 : (if_valid && !at_max) ? starve + 1'b1 : starve;

endmodule

// File: rtl/tinker_mem_arbiter.sv
// tinker_mem_arbiter: shares one fixed-latency memory port between fetch and data traffic; TINKER_MEM_ARB_STATS_EN adds grant statistics
module tinker_mem_arbiter
    import tinker_mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4,
    parameter int MEM_BYTES  = 524288
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [63:0] if_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_rsp_valid,
    output logic [63:0] d_rsp_data,
    output logic        d_rsp_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
`ifdef TINKER_MEM_ARB_STATS_EN
    ,
    output logic [31:0] stat_if_grants,
    output logic [31:0] stat_d_grants,
    output logic [31:0] stat_forced
`endif
);

    localparam int CW = $clog2(MEM_LAT + 1);

    generate
        if (MEM_LAT < 1) begin : g_lat_chk
            $error("MEM_LAT must be at least 1");
        end
        if (STARVE_MAX < 1) begin : g_starve_chk
            $error("STARVE_MAX must be at least 1");
        end
    endgenerate

    state_t        state, state_nx;
    req_t          grant, id_q;
    logic          forced, accept, in_range, we_q, if_done, d_done;
    logic [CW-1:0] cnt;
    logic [63:0]   addr_q, wdata_q, d_data_q, rsp_now, req_addr;
    logic [31:0]   if_data_q;

    tinker_mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .clk     (clk),
        .reset   (reset),
        .if_valid(if_req_valid),
        .d_valid (d_req_valid),
        .accept  (accept),
        .grant   (grant),
        .forced  (forced)
    );

    assign if_req_ready = reset && state == IDLE && grant == REQ_IF && if_req_valid;
    assign d_req_ready  = reset && state == IDLE && grant == REQ_D && d_req_valid;
    assign accept       = if_req_ready || d_req_ready;
    assign req_addr     = grant == REQ_IF ? if_addr : d_addr;
    assign in_range     = ({1'b0, req_addr} + 65'(grant == REQ_IF ? IF_BYTES - 1 : D_BYTES - 1)) < 65'(MEM_BYTES);

    // Next state: walk one access through issue/wait/resp, or take the single-cycle error branch
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE  ? (accept ? (in_range ? ISSUE : ERR) : IDLE)
                 : state == ISSUE ? (MEM_LAT == 1 ? RESP : WAIT)
                 : state == WAIT  ? (cnt == CW'(MEM_LAT - 1) ? RESP : WAIT)
                 : IDLE;
    end

    // State register and access latch; reset discards any in-flight access
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state   <= IDLE;
            id_q    <= REQ_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
        end else begin
            state <= state_nx;
            cnt   <= state == ISSUE ? CW'(1) : state == WAIT ? cnt + 1'b1 : cnt;
            if (accept) begin
                id_q    <= grant;
                we_q    <= grant == REQ_D && d_we;
                addr_q  <= req_addr;
                wdata_q <= grant == REQ_D ? d_wdata : '0;
            end
        end

    assign if_done = (state == RESP || state == ERR) && id_q == REQ_IF;
    assign d_done  = (state == RESP || state == ERR) && id_q == REQ_D;
    assign rsp_now = (state == RESP && !we_q) ? mem_rdata : '0;

    assign if_rsp_valid = if_done;
    assign if_rsp_err   = if_done && state == ERR;
    assign if_rsp_data  = if_done ? rsp_now[31:0] : if_data_q;
    assign d_rsp_valid  = d_done;
    assign d_rsp_err    = d_done && state == ERR;
    assign d_rsp_data   = d_done ? rsp_now : d_data_q;
    assign mem_en       = state == ISSUE;
    assign mem_we       = mem_en && we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;

    // Keep the last response data visible between pulses
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            if_data_q <= '0;
            d_data_q  <= '0;
        end else begin
            if (if_done) if_data_q <= rsp_now[31:0];
            if (d_done) d_data_q <= rsp_now;
        end

`ifdef TINKER_MEM_ARB_STATS_EN
    // Saturating grant statistics, bumped on every accept including out-of-range ones
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            stat_if_grants <= '0;
            stat_d_grants  <= '0;
            stat_forced    <= '0;
        end else if (accept) begin
            if (if_req_ready && stat_if_grants != '1) stat_if_grants <= stat_if_grants + 1'b1;
            if (d_req_ready && stat_d_grants != '1) stat_d_grants <= stat_d_grants + 1'b1;
            if (forced && stat_forced != '1) stat_forced <= stat_forced + 1'b1;
        end
`endif

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// tb_tinker_mem_arbiter: scoreboard bench for tinker_mem_arbiter (stat checks when TINKER_MEM_ARB_STATS_EN is defined)
module tb_tinker_mem_arbiter;

    typedef struct {
        bit          is_if;
        logic [63:0] data;
        bit          err;
        longint      cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req_valid = 1'b0, if_req_ready, if_rsp_valid, if_rsp_err;
    logic [63:0] if_addr = '0;
    logic [31:0] if_rsp_data;
    logic        d_req_valid = 1'b0, d_req_ready, d_we = 1'b0, d_rsp_valid, d_rsp_err;
    logic [63:0] d_addr = '0, d_wdata = '0, d_rsp_data;
    logic        mem_en, mem_we;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
`ifdef TINKER_MEM_ARB_STATS_EN
    logic [31:0] stat_if_grants, stat_d_grants, stat_forced;
`endif

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    exp_t   sb[$];
    exp_t   mon_e;

    bit          v1 = 0, v2 = 0;
    logic [63:0] a1 = '0, a2 = '0;

    tinker_mem_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .if_req_valid(if_req_valid),
        .if_req_ready(if_req_ready),
        .if_addr     (if_addr),
        .if_rsp_valid(if_rsp_valid),
        .if_rsp_data (if_rsp_data),
        .if_rsp_err  (if_rsp_err),
        .d_req_valid (d_req_valid),
        .d_req_ready (d_req_ready),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_data  (d_rsp_data),
        .d_rsp_err   (d_rsp_err),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
`ifdef TINKER_MEM_ARB_STATS_EN
        ,
        .stat_if_grants(stat_if_grants),
        .stat_d_grants (stat_d_grants),
        .stat_forced   (stat_forced)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        return {32'h0BADF00D ^ a[31:0], 32'hDEADBEEF ^ a[31:0] ^ 32'h0000_2000};
    endfunction

    // Memory model: read data appears two cycles after mem_en, junk otherwise
    always @(posedge clk) begin
        v1 <= mem_en;
        a1 <= mem_addr;
        v2 <= v1;
        a2 <= a1;
    end
    assign mem_rdata = v2 ? mem_fn(a2) : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input bit is_if, input logic [63:0] a, input bit we, input bit err, input longint t);
        exp_t        e;
        logic [63:0] m;
        m       = mem_fn(a);
        e.is_if = is_if;
        e.err   = err;
        e.cyc   = t + (err ? 1 : 3);
        e.data  = (err || we) ? 64'h0 : is_if ? {32'h0, m[31:0]} : m;
        sb.push_back(e);
    endtask

    // Monitor: every response pulse must match the oldest expectation
    always @(negedge clk)
        if (if_rsp_valid || d_rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got if=%0d d=%0d expected none", if_rsp_valid, d_rsp_valid);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_both", 64'(if_rsp_valid && d_rsp_valid), 64'h0);
                chk("rsp_who", 64'(if_rsp_valid), 64'(mon_e.is_if));
                chk("rsp_data", mon_e.is_if ? {32'h0, if_rsp_data} : d_rsp_data, mon_e.data);
                chk("rsp_err", 64'(mon_e.is_if ? if_rsp_err : d_rsp_err), 64'(mon_e.err));
                chk("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_left", 64'(sb.size()), 64'h0);
    endtask

    task automatic single(input bit is_if, input logic [63:0] a, input bit we, input logic [63:0] wd, input bit err);
        int n = 0;
        @(negedge clk);
        if (is_if) begin
            if_req_valid = 1'b1;
            if_addr      = a;
        end else begin
            d_req_valid = 1'b1;
            d_addr      = a;
            d_we        = we;
            d_wdata     = wd;
        end
        #1;
        while (!(is_if ? if_req_ready : d_req_ready) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("ready_wait", 64'(n), 64'h0);
        if (n < 50) push_exp(is_if, a, we, err, cyc);
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        d_we         = 1'b0;
        chk("mem_en", 64'(mem_en), 64'(!err));
        if (!err) begin
            chk("mem_we", 64'(mem_we), 64'(we));
            chk("mem_addr", mem_addr, a);
            if (we) chk("mem_wdata", mem_wdata, wd);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int     n, k;
        longint t;
        bit     g[10];
        repeat (3) @(negedge clk);
        chk("rst_mem_en", 64'(mem_en), 64'h0);
        chk("rst_rsp", {if_rsp_valid, if_rsp_err, d_rsp_valid, d_rsp_err}, 64'h0);
        chk("rst_data", {if_rsp_data, d_rsp_data}, 64'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        single(1'b1, 64'h2000, 1'b0, 64'h0, 1'b0);
        chk("t1_hold", 64'(if_rsp_data), 64'hDEADBEEF);

        @(negedge clk);
        if_req_valid = 1'b1;
        if_addr      = 64'h100;
        d_req_valid  = 1'b1;
        d_addr       = 64'h208;
        d_we         = 1'b0;
        #1;
        chk("t2_d_first", {d_req_ready, if_req_ready}, 64'h2);
        t = cyc;
        push_exp(1'b0, 64'h208, 1'b0, 1'b0, t);
        @(posedge clk);
        #1;
        d_req_valid = 1'b0;
        n = 0;
        while (!if_req_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t2_if_cycle", 64'(cyc), 64'(t + 4));
        push_exp(1'b1, 64'h100, 1'b0, 1'b0, cyc);
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
        drain();

        @(negedge clk);
        if_req_valid = 1'b1;
        if_addr      = 64'h100;
        d_req_valid  = 1'b1;
        d_addr       = 64'h200;
        k = 0;
        n = 0;
        while (k < 10 && n < 200) begin
            #1;
            if (if_req_ready || d_req_ready) begin
                chk("t3_one_ready", 64'(if_req_ready && d_req_ready), 64'h0);
                g[k] = if_req_ready;
                push_exp(if_req_ready, if_req_ready ? 64'h100 : 64'h200, 1'b0, 1'b0, cyc);
                k++;
            end
            @(negedge clk);
            n++;
        end
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        chk("t3_accepts", 64'(k), 64'd10);
        for (int i = 0; i < k; i++) chk($sformatf("t3_grant%0d", i), 64'(g[i]), 64'(i == 4 || i == 9));
`ifdef TINKER_MEM_ARB_STATS_EN
        chk("t3_stat_forced", 64'(stat_forced), 64'd2);
`endif
        drain();

        single(1'b0, 64'h7FFF8, 1'b1, 64'h1122334455667788, 1'b0);
        single(1'b0, 64'h7FFF9, 1'b0, 64'h0, 1'b1);
        single(1'b1, 64'h7FFFD, 1'b0, 64'h0, 1'b1);
        single(1'b1, 64'h7FFFC, 1'b0, 64'h0, 1'b0);

        @(negedge clk);
        if_req_valid = 1'b1;
        if_addr      = 64'h40;
        #1;
        chk("t6_ready", 64'(if_req_ready), 64'h1);
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("t6_mem", {mem_en, mem_we}, 64'h0);
        chk("t6_rsp", {if_rsp_valid, if_rsp_err, d_rsp_valid, d_rsp_err}, 64'h0);
        chk("t6_addr", mem_addr, 64'h0);
        chk("t6_data", {if_rsp_data, d_rsp_data}, 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_no_mem_en", 64'(mem_en), 64'h0);
        end
        single(1'b1, 64'h3000, 1'b0, 64'h0, 1'b0);

        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
